flit_tx: RTL

FLIT_TX -- requirements
Module: flit_tx

---
 rtl/flit_pkg.sv | 24 ++
 rtl/credit_counter.sv | 39 +++
 rtl/flit_tx.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/flit_pkg.sv
// Shared definitions for the flit transmitter: flit field positions, flit type codes
// and the transmit FSM state encoding.
package flit_pkg;

  localparam int unsigned TYPE_HI = 63;
  localparam int unsigned TYPE_LO = 62;
  localparam int unsigned X_HI    = 8;
  localparam int unsigned X_LO    = 6;
  localparam int unsigned Y_HI    = 11;
  localparam int unsigned Y_LO    = 9;

  localparam logic [1:0] HEAD = 2'b11;
  localparam logic [1:0] BODY = 2'b01;
  localparam logic [1:0] TAIL = 2'b10;
  localparam logic [1:0] INV  = 2'b00;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_CRED = 2'd1,
    PUSH      = 2'd2,
    PKT       = 2'd3
  } tx_state_t;

endpackage

// File: rtl/credit_counter.sv
// Free-slot counter for the downstream buffer; saturates at both ends and flags
// the offending increment/decrement combinationally.
module credit_counter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_c,
  output logic             underflow_c
);

  logic [CNT_W-1:0] count_q, count_d;

  // Simultaneous inc and dec cancel out.
  always_comb begin
    count_d     = count_q;
    overflow_c  = 1'b0;
    underflow_c = 1'b0;
    if (inc_i && !dec_i) begin
      if (count_q == CNT_W'(DEPTH)) overflow_c = 1'b1;
      else                          count_d    = count_q + CNT_W'(1);
    end else if (dec_i && !inc_i) begin
      if (count_q == '0) underflow_c = 1'b1;
      else               count_d     = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= CNT_W'(DEPTH);
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/flit_tx.sv
// Credit-based flit transmitter: a packet is only started once the downstream buffer
// is completely free. Optional push watchdog enabled by FLIT_TX_TIMEOUT_EN.
module flit_tx
  import flit_pkg::*;
#(
  parameter int unsigned FLIT_W  = 64,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              src_valid,
  input  logic [FLIT_W-1:0] src_flit,
  output logic              src_ready,
  output logic              push_x,
  output logic [FLIT_W-1:0] flit_out,
  input  logic              push_ack,
  input  logic              credit_ret,
  output logic [2:0]        em_pl,
  output logic              busy,
  output logic              err
);

  localparam int unsigned CNT_W = 3;

  if (FLIT_W < TYPE_HI + 1 || DEPTH < 1 || DEPTH > 7 || TIMEOUT < 1) begin : g_bad_param
    $error("flit_tx: unsupported FLIT_W/DEPTH/TIMEOUT");
  end

  tx_state_t         state_q, state_d;
  logic [FLIT_W-1:0] flit_q, flit_d;
  logic              src_ready_q, push_x_q, busy_q, err_q;
  logic [1:0]        src_type, cur_type;
  logic              accept, push_done, drop_err, timeout_hit;
  logic              cred_full, cred_ovf, cred_unf;
  logic [CNT_W-1:0]  credits;

  assign src_type  = src_flit[TYPE_HI:TYPE_LO];
  assign cur_type  = flit_q[TYPE_HI:TYPE_LO];
  assign accept    = src_valid && src_ready_q;
  assign push_done = push_x_q && push_ack;
  assign cred_full = (credits == CNT_W'(DEPTH));

  credit_counter #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_credit (
    .clk         (clk),
    .rst_n       (reset),
    .inc_i       (credit_ret),
    .dec_i       (push_done),
    .count_o     (credits),
    .overflow_c  (cred_ovf),
    .underflow_c (cred_unf)
  );

`ifdef FLIT_TX_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_q, wd_d;

  // Counts stalled push cycles; expiry abandons the packet.
  always_comb begin
    wd_d        = '0;
    timeout_hit = 1'b0;
    if (push_x_q && !push_ack) begin
      if (wd_q == WD_W'(TIMEOUT - 1)) timeout_hit = 1'b1;
      else                            wd_d        = wd_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    flit_d   = flit_q;
    drop_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (src_type == HEAD) begin
            flit_d  = src_flit;
            state_d = WAIT_CRED;
          end else begin
            drop_err = 1'b1;
          end
        end
      end
      // Whole-packet reservation: wait for an empty downstream buffer.
      WAIT_CRED: begin
        if (cred_full) state_d = PUSH;
      end
      PUSH: begin
        if (push_ack)         state_d = (cur_type == TAIL) ? IDLE : PKT;
        else if (timeout_hit) state_d = IDLE;
      end
      PKT: begin
        if (accept) begin
          if (src_type == BODY || src_type == TAIL) begin
            flit_d  = src_flit;
            state_d = PUSH;
          end else begin
            drop_err = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      flit_q      <= '0;
      src_ready_q <= 1'b1;
      push_x_q    <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      flit_q      <= flit_d;
      src_ready_q <= (state_d == IDLE) || (state_d == PKT);
      push_x_q    <= (state_d == PUSH);
      busy_q      <= (state_d != IDLE);
      err_q       <= drop_err || cred_ovf || cred_unf || timeout_hit;
    end
  end

  assign src_ready = src_ready_q;
  assign push_x    = push_x_q;
  assign flit_out  = flit_q;
  assign em_pl     = credits;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
